// File: rtl/axi_b_resp_gen_if.sv
// Handshake bundle between the AW/completion sources, the B-response generator
// and the downstream B buffer.
interface axi_b_resp_gen_if #(
  parameter int ID_WIDTH   = 16,
  parameter int USER_WIDTH = 10,
  parameter int BUFF_DEPTH = 4
);
  localparam int CNT_W = $clog2(BUFF_DEPTH + 1);

  logic                  aw_valid_i;
  logic [ID_WIDTH-1:0]   aw_id_i;
  logic [USER_WIDTH-1:0] aw_user_i;
  logic                  aw_ready_o;
  logic                  done_valid_i;
  logic                  done_err_i;
  logic                  done_ready_o;
  logic                  b_valid_o;
  logic [1:0]            b_resp_o;
  logic [ID_WIDTH-1:0]   b_id_o;
  logic [USER_WIDTH-1:0] b_user_o;
  logic                  b_ready_i;
  logic [CNT_W-1:0]      outstanding_o;

  modport master (
    output aw_valid_i, aw_id_i, aw_user_i, done_valid_i, done_err_i, b_ready_i,
    input  aw_ready_o, done_ready_o, b_valid_o, b_resp_o, b_id_o, b_user_o, outstanding_o
  );

  modport slave (
    input  aw_valid_i, aw_id_i, aw_user_i, done_valid_i, done_err_i, b_ready_i,
    output aw_ready_o, done_ready_o, b_valid_o, b_resp_o, b_id_o, b_user_o, outstanding_o
  );
endinterface

// File: rtl/axi_b_resp_gen.sv
// AXI B-response generator: queues accepted AW ID/USER in order and turns each completion
// into a registered B beat. Optional watchdog/DECERR path: AXI_B_RESP_GEN_TIMEOUT_EN.
module axi_b_resp_gen #(
  parameter int ID_WIDTH       = 16,
  parameter int USER_WIDTH     = 10,
  parameter int BUFF_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic             clk_i,
  input logic             rst_ni,
  axi_b_resp_gen_if.slave bus
);
  localparam int PTR_W = $clog2(BUFF_DEPTH);
  localparam int CNT_W = $clog2(BUFF_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(BUFF_DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT    = {CNT_W{1'b0}};
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  if (BUFF_DEPTH < 2 || (BUFF_DEPTH & (BUFF_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("axi_b_resp_gen: BUFF_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e                state_r, state_next_s;
  logic [ID_WIDTH-1:0]   id_mem_r   [BUFF_DEPTH];
  logic [USER_WIDTH-1:0] user_mem_r [BUFF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [1:0]            b_resp_r, load_resp_s;
  logic [ID_WIDTH-1:0]   b_id_r;
  logic [USER_WIDTH-1:0] b_user_r;
  logic                  aw_ready_s, done_ready_s, load_ok_s;
  logic                  push_s, done_hs_s, pop_s;

`ifdef AXI_B_RESP_GEN_TIMEOUT_EN
  localparam int               WD_W        = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_MAX      = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RESP_DECERR = 2'b11;
  logic [WD_W-1:0]  wd_r;
  logic [CNT_W-1:0] drop_r;
  logic             drop_hs_s, timeout_s;
`endif

  // Handshake qualifiers; ready signals look only at registered state, never at valids.
  always_comb begin
    aw_ready_s = (count_r != FULL_CNT);
    load_ok_s  = (state_r == ST_EMPTY) || bus.b_ready_i;
    push_s     = bus.aw_valid_i && aw_ready_s;
`ifdef AXI_B_RESP_GEN_TIMEOUT_EN
    // Completions owed to timed-out entries are swallowed without needing a queue entry.
    done_ready_s = (drop_r != ZERO_CNT) || ((count_r != ZERO_CNT) && load_ok_s);
    done_hs_s    = bus.done_valid_i && done_ready_s;
    drop_hs_s    = done_hs_s && (drop_r != ZERO_CNT);
    timeout_s    = (wd_r == WD_MAX) && (count_r != ZERO_CNT) && load_ok_s &&
                   (drop_r != FULL_CNT) && !done_hs_s;
    pop_s        = (done_hs_s && !drop_hs_s) || timeout_s;
    if (timeout_s) begin
      load_resp_s = RESP_DECERR;
    end else if (bus.done_err_i) begin
      load_resp_s = RESP_SLVERR;
    end else begin
      load_resp_s = RESP_OKAY;
    end
`else
    done_ready_s = (count_r != ZERO_CNT) && load_ok_s;
    done_hs_s    = bus.done_valid_i && done_ready_s;
    pop_s        = done_hs_s;
    if (bus.done_err_i) begin
      load_resp_s = RESP_SLVERR;
    end else begin
      load_resp_s = RESP_OKAY;
    end
`endif
  end

  // Output-register next state: a pop always reloads, otherwise a taken beat empties it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (pop_s) state_next_s = ST_FULL;
        else       state_next_s = ST_EMPTY;
      end
      ST_FULL: begin
        if (pop_s)                state_next_s = ST_FULL;
        else if (bus.b_ready_i)   state_next_s = ST_EMPTY;
        else                      state_next_s = ST_FULL;
      end
      default: state_next_s = ST_EMPTY;
    endcase
  end

  // State register for the B output stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_r <= ST_EMPTY;
    else         state_r <= state_next_s;
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= ZERO_CNT;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful under the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      id_mem_r[wr_ptr_r]   <= bus.aw_id_i;
      user_mem_r[wr_ptr_r] <= bus.aw_user_i;
    end
  end

  // B beat payload; loaded from the FIFO head on every pop, held otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_resp_r <= RESP_OKAY;
      b_id_r   <= {ID_WIDTH{1'b0}};
      b_user_r <= {USER_WIDTH{1'b0}};
    end else if (pop_s) begin
      b_resp_r <= load_resp_s;
      b_id_r   <= id_mem_r[rd_ptr_r];
      b_user_r <= user_mem_r[rd_ptr_r];
    end
  end

`ifdef AXI_B_RESP_GEN_TIMEOUT_EN
  // Watchdog on the head entry and count of completions still owed to timed-out entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_r   <= {WD_W{1'b0}};
      drop_r <= ZERO_CNT;
    end else begin
      if ((count_r == ZERO_CNT) || done_hs_s || timeout_s) wd_r <= {WD_W{1'b0}};
      else if (wd_r != WD_MAX)                             wd_r <= wd_r + WD_W'(1);
      else                                                 wd_r <= wd_r;
      if (timeout_s)      drop_r <= drop_r + CNT_W'(1);
      else if (drop_hs_s) drop_r <= drop_r - CNT_W'(1);
      else                drop_r <= drop_r;
    end
  end
`endif

  assign bus.aw_ready_o    = aw_ready_s;
  assign bus.done_ready_o  = done_ready_s;
  assign bus.b_valid_o     = (state_r == ST_FULL);
  assign bus.b_resp_o      = b_resp_r;
  assign bus.b_id_o        = b_id_r;
  assign bus.b_user_o      = b_user_r;
  assign bus.outstanding_o = count_r;
endmodule

// File: tb/tb_axi_b_resp_gen.sv
// Directed self-checking bench for axi_b_resp_gen; inputs change and outputs are
// sampled on the falling edge.
module tb_axi_b_resp_gen;
  localparam int ID_W = 16, USER_W = 10, DEPTH = 4, TMO = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  axi_b_resp_gen_if #(.ID_WIDTH(ID_W), .USER_WIDTH(USER_W), .BUFF_DEPTH(DEPTH)) bus ();

  axi_b_resp_gen #(
    .ID_WIDTH(ID_W), .USER_WIDTH(USER_W), .BUFF_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.aw_valid_i   = 1'b0;
    bus.aw_id_i      = 16'h0000;
    bus.aw_user_i    = 10'h000;
    bus.done_valid_i = 1'b0;
    bus.done_err_i   = 1'b0;
    bus.b_ready_i    = 1'b0;
  endtask

  task automatic push_aw(input logic [15:0] id, input logic [9:0] user);
    bus.aw_valid_i = 1'b1;
    bus.aw_id_i    = id;
    bus.aw_user_i  = user;
    cyc();
    bus.aw_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) cyc();
    checks++;
    if ({bus.aw_ready_o, bus.done_ready_o, bus.b_valid_o, bus.b_resp_o, bus.b_id_o, bus.b_user_o,
         bus.outstanding_o} !== {1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 10'h000, 3'd0}) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", {bus.aw_ready_o, bus.done_ready_o, bus.b_valid_o,
               bus.b_resp_o, bus.b_id_o, bus.b_user_o, bus.outstanding_o},
               {1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 10'h000, 3'd0});
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    push_aw(16'h0012, 10'h003);
    checks++;
    if (bus.outstanding_o !== 3'd1 || bus.done_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL single_queued got=%0d/%b exp=1/1", bus.outstanding_o, bus.done_ready_o);
    end
    bus.done_valid_i = 1'b1;
    bus.done_err_i   = 1'b0;
    cyc();
    bus.done_valid_i = 1'b0;
    checks++;
    if ({bus.b_valid_o, bus.b_resp_o, bus.b_id_o, bus.b_user_o} !== {1'b1, 2'b00, 16'h0012, 10'h003}) begin
      failures++;
      $display("FAIL single_beat got=%h exp=%h", {bus.b_valid_o, bus.b_resp_o, bus.b_id_o, bus.b_user_o},
               {1'b1, 2'b00, 16'h0012, 10'h003});
    end
    repeat (2) cyc();
    checks++;
    if ({bus.b_valid_o, bus.b_id_o, bus.outstanding_o} !== {1'b1, 16'h0012, 3'd0}) begin
      failures++;
      $display("FAIL single_hold got=%h exp=%h", {bus.b_valid_o, bus.b_id_o, bus.outstanding_o},
               {1'b1, 16'h0012, 3'd0});
    end
    bus.b_ready_i = 1'b1;
    cyc();
    bus.b_ready_i = 1'b0;
    checks++;
    if (bus.b_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_drain got=%b exp=0", bus.b_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_resp;
    for (int i = 1; i <= 4; i++) push_aw(16'(i), 10'(16 + i));
    checks++;
    if (bus.aw_ready_o !== 1'b0 || bus.outstanding_o !== 3'd4) begin
      failures++;
      $display("FAIL full_flags got=%b/%0d exp=0/4", bus.aw_ready_o, bus.outstanding_o);
    end
    push_aw(16'h0055, 10'h055);
    checks++;
    if (bus.outstanding_o !== 3'd4) begin
      failures++;
      $display("FAIL full_no_push got=%0d exp=4", bus.outstanding_o);
    end
    bus.b_ready_i = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        exp_resp = (k == 2) ? 2'b10 : 2'b00;
        checks++;
        if ({bus.b_valid_o, bus.b_id_o, bus.b_resp_o, bus.b_user_o} !== {1'b1, 16'(k), exp_resp, 10'(16 + k)}) begin
          failures++;
          $display("FAIL b2b_beat%0d got=%h exp=%h", k, {bus.b_valid_o, bus.b_id_o, bus.b_resp_o, bus.b_user_o},
                   {1'b1, 16'(k), exp_resp, 10'(16 + k)});
        end
      end
      if (k < 4) begin
        checks++;
        if (bus.done_ready_o !== 1'b1) begin
          failures++;
          $display("FAIL b2b_ready%0d got=%b exp=1", k, bus.done_ready_o);
        end
        bus.done_valid_i = 1'b1;
        bus.done_err_i   = (k == 1);
      end else begin
        bus.done_valid_i = 1'b0;
        bus.done_err_i   = 1'b0;
      end
      cyc();
    end
    checks++;
    if (bus.b_valid_o !== 1'b0 || bus.outstanding_o !== 3'd0) begin
      failures++;
      $display("FAIL b2b_end got=%b/%0d exp=0/0", bus.b_valid_o, bus.outstanding_o);
    end
    bus.b_ready_i = 1'b0;
  endtask

  task automatic test_stall();
    push_aw(16'h0021, 10'h021);
    push_aw(16'h0022, 10'h022);
    bus.b_ready_i    = 1'b0;
    bus.done_valid_i = 1'b1;
    bus.done_err_i   = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.done_ready_o, bus.b_valid_o, bus.b_id_o, bus.outstanding_o} !== {1'b0, 1'b1, 16'h0021, 3'd1}) begin
        failures++;
        $display("FAIL stall_hold%0d got=%h exp=%h", i, {bus.done_ready_o, bus.b_valid_o, bus.b_id_o,
                 bus.outstanding_o}, {1'b0, 1'b1, 16'h0021, 3'd1});
      end
      cyc();
    end
    bus.b_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.done_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ready got=%b exp=1", bus.done_ready_o);
    end
    cyc();
    checks++;
    if ({bus.b_valid_o, bus.b_id_o, bus.outstanding_o} !== {1'b1, 16'h0022, 3'd0}) begin
      failures++;
      $display("FAIL stall_next_beat got=%h exp=%h", {bus.b_valid_o, bus.b_id_o, bus.outstanding_o},
               {1'b1, 16'h0022, 3'd0});
    end
    bus.done_valid_i = 1'b0;
    cyc();
    checks++;
    if (bus.b_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_drain got=%b exp=0", bus.b_valid_o);
    end
    bus.b_ready_i = 1'b0;
  endtask

  task automatic test_empty_stall();
    bus.b_ready_i    = 1'b1;
    bus.done_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (bus.done_ready_o !== 1'b0 || bus.b_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL empty_stall%0d got=%b/%b exp=0/0", i, bus.done_ready_o, bus.b_valid_o);
      end
    end
    bus.aw_valid_i = 1'b1;
    bus.aw_id_i    = 16'h0007;
    bus.aw_user_i  = 10'h007;
    #1;
    checks++;
    if (bus.done_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL empty_push_cycle got=%b exp=0", bus.done_ready_o);
    end
    cyc();
    bus.aw_valid_i = 1'b0;
    checks++;
    if (bus.done_ready_o !== 1'b1 || bus.outstanding_o !== 3'd1) begin
      failures++;
      $display("FAIL empty_after_push got=%b/%0d exp=1/1", bus.done_ready_o, bus.outstanding_o);
    end
    cyc();
    bus.done_valid_i = 1'b0;
    checks++;
    if ({bus.b_valid_o, bus.b_id_o, bus.b_resp_o} !== {1'b1, 16'h0007, 2'b00}) begin
      failures++;
      $display("FAIL empty_beat got=%h exp=%h", {bus.b_valid_o, bus.b_id_o, bus.b_resp_o}, {1'b1, 16'h0007, 2'b00});
    end
    cyc();
    bus.b_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) push_aw(16'(49 + i), 10'(49 + i));
    bus.b_ready_i    = 1'b0;
    bus.done_valid_i = 1'b1;
    cyc();
    bus.done_valid_i = 1'b0;
    checks++;
    if (bus.b_valid_o !== 1'b1 || bus.outstanding_o !== 3'd3) begin
      failures++;
      $display("FAIL rstmid_pre got=%b/%0d exp=1/3", bus.b_valid_o, bus.outstanding_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.aw_ready_o, bus.done_ready_o, bus.b_valid_o, bus.b_resp_o, bus.b_id_o, bus.b_user_o,
         bus.outstanding_o} !== {1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 10'h000, 3'd0}) begin
      failures++;
      $display("FAIL rstmid_async got=%h exp=%h", {bus.aw_ready_o, bus.done_ready_o, bus.b_valid_o,
               bus.b_resp_o, bus.b_id_o, bus.b_user_o, bus.outstanding_o},
               {1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 10'h000, 3'd0});
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    checks++;
    if ({bus.aw_ready_o, bus.done_ready_o, bus.b_valid_o, bus.outstanding_o} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL rstmid_after got=%h exp=%h", {bus.aw_ready_o, bus.done_ready_o, bus.b_valid_o,
               bus.outstanding_o}, {1'b1, 1'b0, 1'b0, 3'd0});
    end
  endtask

`ifdef AXI_B_RESP_GEN_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bus.b_ready_i = 1'b1;
    push_aw(16'h0009, 10'h009);
    n = 1;
    while (bus.b_valid_o !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    checks++;
    if (n !== 17 || {bus.b_resp_o, bus.b_id_o, bus.b_user_o} !== {2'b11, 16'h0009, 10'h009}) begin
      failures++;
      $display("FAIL timeout_beat got=%0d/%h exp=17/%h", n, {bus.b_resp_o, bus.b_id_o, bus.b_user_o},
               {2'b11, 16'h0009, 10'h009});
    end
    cyc();
    bus.done_valid_i = 1'b1;
    checks++;
    if (bus.done_ready_o !== 1'b1 || bus.b_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_late_ready got=%b/%b exp=1/0", bus.done_ready_o, bus.b_valid_o);
    end
    cyc();
    bus.done_valid_i = 1'b0;
    checks++;
    if (bus.b_valid_o !== 1'b0 || bus.done_ready_o !== 1'b0 || bus.outstanding_o !== 3'd0) begin
      failures++;
      $display("FAIL timeout_swallow got=%b/%b/%0d exp=0/0/0", bus.b_valid_o, bus.done_ready_o, bus.outstanding_o);
    end
    push_aw(16'h000A, 10'h00A);
    bus.done_valid_i = 1'b1;
    cyc();
    bus.done_valid_i = 1'b0;
    checks++;
    if ({bus.b_valid_o, bus.b_id_o, bus.b_resp_o} !== {1'b1, 16'h000A, 2'b00}) begin
      failures++;
      $display("FAIL timeout_next_ok got=%h exp=%h", {bus.b_valid_o, bus.b_id_o, bus.b_resp_o}, {1'b1, 16'h000A, 2'b00});
    end
    cyc();
    bus.b_ready_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_empty_stall();
    test_reset_mid();
`ifdef AXI_B_RESP_GEN_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_b_resp_gen.md
Name: axi_b_resp_gen

Overview:
Upstream neighbour of the AXI B-channel slave buffer in the accelerator AXI bridge. It records each accepted AW (ID, USER) in an in-order outstanding-write FIFO. It pairs each downstream write-completion strobe with the oldest outstanding entry. It drives a registered AXI B beat (valid/resp/id/user) into the B buffer with standard valid/ready handshaking.

Parameters:
ID_WIDTH, 16, AXI ID width
USER_WIDTH, 10, AXI USER width
BUFF_DEPTH, 4, outstanding-write FIFO entries; power of two, >= 2
TIMEOUT_CYCLES, 1024, watchdog limit (optional feature only)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
aw_valid_i  in  1  AW accepted-address strobe
aw_id_i  in  ID_WIDTH  AW ID
aw_user_i  in  USER_WIDTH  AW USER
aw_ready_o  out  1  FIFO can accept an entry
done_valid_i  in  1  downstream write completed
done_err_i  in  1  completion carried an error
done_ready_o  out  1  completion accepted
b_valid_o  out  1  B beat valid
b_resp_o  out  2  B response
b_id_o  out  ID_WIDTH  B ID
b_user_o  out  USER_WIDTH  B USER
b_ready_i  in  1  B buffer ready
outstanding_o  out  $clog2(BUFF_DEPTH+1)  entries in FIFO

Behaviour:
- Reset values: aw_ready_o=1, done_ready_o=0, b_valid_o=0, b_resp_o=2'b00, b_id_o=0, b_user_o=0, outstanding_o=0. FIFO pointers are cleared. Any in-flight beat or entry is discarded; reset mid-operation is legal.
- FIFO:
  - wr_ptr and rd_ptr are $clog2(BUFF_DEPTH) bits and wrap modulo BUFF_DEPTH.
  - A separate count register drives outstanding_o directly.
  - aw_ready_o = (count != BUFF_DEPTH). Push occurs when aw_valid_i & aw_ready_o.
  - A same-cycle pop never frees space for a push when the FIFO is full; aw_ready_o is combinational on the registered count only.
- Output register state machine, two states:
  - EMPTY: b_valid_o=0.
  - FULL: b_valid_o=1; the beat is held stable until b_ready_i.
  - EMPTY -> FULL on a completion handshake.
  - FULL -> EMPTY on b_ready_i with no new completion.
  - FULL -> FULL when b_ready_i and a new completion occur in the same cycle (back-to-back, one beat per cycle).
- done_ready_o = (count != 0) & (state==EMPTY | b_ready_i).
  - A completion with an empty FIFO is stalled, never dropped.
  - done_ready_o must not depend on done_valid_i.
- On a completion handshake:
  - Pop the FIFO head.
  - Next cycle: b_id_o/b_user_o = head entry, b_resp_o = done_err_i ? 2'b10 (SLVERR) : 2'b00 (OKAY).
  - Latency from completion handshake to b_valid_o is exactly 1 cycle.
- Same-cycle push and pop: count unchanged, both pointers advance.
- Push into an empty FIFO with a same-cycle completion: the completion is not accepted that cycle, because done_ready_o uses the registered count. It is accepted the following cycle.
- Order: B beats carry IDs in exact AW acceptance order. No ID reordering.
- EXOKAY (2'b01) is never generated.

Optional Feature:
Macro AXI_B_RESP_GEN_TIMEOUT_EN.
- When defined:
  - A watchdog counter runs while count!=0 and no completion handshake occurs. It clears on each handshake or when the FIFO becomes empty.
  - On reaching TIMEOUT_CYCLES-1 with the output register able to load (same condition as done_ready_o), the block pops the head. It issues b_resp_o=2'b11 (DECERR) for that head's ID/USER and increments a drop counter.
  - Each subsequent completion handshake arriving while drop>0 is consumed (done_ready_o=1 when drop>0, independent of count). That completion is discarded with no B beat, and drop is decremented.
  - Drop counter width matches count.
  - Drop counter saturates at BUFF_DEPTH; a timeout is not taken while drop==BUFF_DEPTH.
- When not defined: no counters exist, behaviour is exactly as above, and a stuck completion stalls forever.

Test Plan:
- Reset release, one AW id=0x12 user=0x3, then done_valid_i with err=0 -> 1 cycle after the completion handshake, b_valid_o=1, b_id_o=0x12, b_user_o=0x3, b_resp_o=00; held until b_ready_i.
- 4 AWs ids 1..4 with no completions -> aw_ready_o=0 after the 4th, outstanding_o=4. Then 4 completions (2nd with err=1) and b_ready_i=1 -> beats ids 1,2,3,4 back-to-back, resps 00,10,00,00.
- b_ready_i=0 with a beat pending, done_valid_i held high, 2 entries queued -> done_ready_o=0, beat is stable. Raise b_ready_i -> next completion accepted the same cycle, no bubble.
- done_valid_i=1 with an empty FIFO for 5 cycles, then AW id=7 -> done_ready_o stays 0 until the cycle after the push; beat id=7 follows.
- Reset asserted with a FIFO of 3 entries and b_valid_o=1 -> all outputs at reset values immediately, outstanding_o=0.
- (TIMEOUT_EN, TIMEOUT_CYCLES=16) AW id=9, no completion -> DECERR beat id=9 after the timeout. A late completion is then consumed silently; the next AW id=A plus completion gives an OKAY beat id=A.
